// File: rtl/spi_pkg.sv
// spi_pkg: state/substage types and command codes shared by the SPI slave.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} spi_state_t;
  typedef enum logic [1:0] {RX, WAIT_TX, TX} rd_sub_t;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_shift_tx.sv
// spi_shift_tx: MISO load/shift register; last flags that the next shift drives bit 0.
module spi_shift_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              dout,
  output logic              last
);
  localparam int CW = $clog2(DATA_W);
  logic [DATA_W-1:0] sh;
  logic [CW-1:0] cnt;
  assign dout = sh[DATA_W-1];
  assign last = cnt == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= din;
      cnt <= CW'(DATA_W - 1);
    end else if (shift_en) begin
      sh  <= {sh[DATA_W-2:0], 1'b0};
      cnt <= cnt - CW'(cnt != '0);
    end
endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave front-end for the SPI-to-RAM path.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse on aborted RX words or TX transfers.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CMD_W  = 2,
  localparam int RX_W  = DATA_W + CMD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [RX_W-1:0]   rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              rd_pending
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);
  localparam int CW = $clog2(RX_W);
  spi_state_t state, state_nxt;
  rd_sub_t sub, sub_nxt;
  logic [CW-1:0] rx_cnt;
  logic [RX_W-2:0] rx_sh;
  logic rx_phase, tx_phase, rx_en, word_done, load, shift_en, clr, last;
  assign rx_phase  = state == WRITE || state == READ_ADD || (state == READ_DATA && sub == RX);
  assign tx_phase  = state == READ_DATA && sub == TX;
  assign rx_en     = rx_phase && !SS_n;
  assign word_done = rx_en && rx_cnt == '0;
  always_comb begin
    state_nxt = state;
    sub_nxt   = sub;
    load      = 1'b0;
    shift_en  = 1'b0;
    clr       = 1'b0;
    if (state != IDLE && SS_n) begin
      state_nxt = IDLE;
      sub_nxt   = RX;
      clr       = 1'b1;
    end else if (state == IDLE) begin
      state_nxt = SS_n ? IDLE : CHK_CMD;
    end else if (state == CHK_CMD) begin
      state_nxt = !MOSI ? WRITE : rd_pending ? READ_DATA : READ_ADD;
    end else if (state == READ_DATA) begin
      if (sub == RX && word_done) sub_nxt = WAIT_TX;
      if (sub == WAIT_TX && tx_valid) begin
        load    = 1'b1;
        sub_nxt = TX;
      end
      // rd_pending drops on the edge that drives bit 0, so low here means the byte is out
      if (tx_phase) begin
        shift_en = rd_pending;
        clr      = !rd_pending;
        sub_nxt  = rd_pending ? TX : RX;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sub   <= RX;
    end else begin
      state <= state_nxt;
      sub   <= sub_nxt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_cnt     <= '0;
      rx_sh      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (state == CHK_CMD) rx_cnt <= CW'(RX_W - 1);
      else if (rx_en) rx_cnt <= word_done ? CW'(RX_W - 1) : rx_cnt - CW'(1);
      if (rx_en) rx_sh <= {rx_sh[RX_W-3:0], MOSI};
      if (word_done) rx_data <= {rx_sh, MOSI};
      if (word_done && state == READ_ADD) rd_pending <= 1'b1;
      else if ((shift_en && last) || (tx_phase && SS_n)) rd_pending <= 1'b0;
    end
  spi_shift_tx #(.DATA_W(DATA_W)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .clr      (clr),
    .din      (tx_data),
    .dout     (MISO),
    .last     (last)
  );
`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_err <= 1'b0;
    else frame_err <= SS_n && ((rx_phase && rx_cnt != CW'(RX_W - 1)) || (tx_phase && rd_pending));
`endif
endmodule
